// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and the buffered fetch entry.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RETRY,
        DRAIN,
        FAULT
    } fetch_state_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries between the bus master and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Wishbone classic read master fetching instruction words into a small FIFO for decode.
//
// state | meaning
// IDLE  | bus quiet; issue a read when the FIFO has room
// REQ   | read outstanding at adr_o; waiting for ack/err/rty or watchdog
// RETRY | one bus-idle cycle after rty, then reissue the same address
// DRAIN | redirected mid-read; finish the old read and discard it
// FAULT | bus error or watchdog expiry; parked until redirect
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          FIFO_DEPTH     = 2,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   adr_q;
    logic [WW-1:0] wd;
    logic          timeout;
    logic          resp;
    logic          push;
    logic          set_fault;
    fetch_entry_t  fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign timeout = (wd == WW'(TIMEOUT_CYCLES - 1));
    assign resp    = ack_i || err_i || rty_i || timeout;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        set_fault  = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_i && fifo_count < CW'(FIFO_DEPTH)) state_next = REQ;
            end
            REQ: begin
                // A response arriving with the redirect already ends the read.
                if (redirect_i) begin
                    state_next = resp ? IDLE : DRAIN;
                end else if (err_i) begin
                    state_next = FAULT;
                    set_fault  = 1'b1;
                end else if (ack_i) begin
                    state_next = IDLE;
                    push       = 1'b1;
                end else if (rty_i) begin
                    state_next = RETRY;
                end else if (timeout) begin
                    state_next = FAULT;
                    set_fault  = 1'b1;
                end
            end
            RETRY:   state_next = redirect_i ? IDLE : REQ;
            DRAIN:   if (resp) state_next = IDLE;
            FAULT:   if (redirect_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            adr_q      <= RESET_PC;
            wd         <= '0;
            fault_o    <= 1'b0;
            fault_pc_o <= '0;
        end else begin
            state <= state_next;
            if (state_next == state && (state == REQ || state == DRAIN)) begin
                wd <= wd + 1'b1;
            end else begin
                wd <= '0;
            end
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                fault_o  <= 1'b0;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'(WORD_BYTES);
            end
            if (state == IDLE && state_next == REQ) adr_q <= fetch_pc;
            if (set_fault) begin
                fault_o    <= 1'b1;
                fault_pc_o <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push && !fifo_full),
        .push_data ('{pc: adr_q, instr: dat_i}),
        .pop       (valid_o && ready_i && !redirect_i),
        .flush     (redirect_i),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign cyc_o   = (state == REQ) || (state == DRAIN);
    assign stb_o   = cyc_o;
    assign adr_o   = adr_q;
    assign sel_o   = 4'hF;
    assign we_o    = 1'b0;
    assign dat_o   = '0;
    assign valid_o = !fifo_empty;
    assign instr_o = fifo_head.instr;
    assign pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: flash slave emulator, stream model of the delivered words, directed scenarios.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam int          FIFO_DEPTH     = 2;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam logic [31:0] RTY_ADDR       = 32'h0000_0040;
    localparam logic [31:0] ERR_ADDR       = 32'h0000_03F0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_o, stb_o, we_o, valid_o, fault_o;
    logic [31:0] adr_o, dat_o, instr_o, pc_o, fault_pc_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ready_i = 1'b0;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          rty_arm = 1'b0;
    int          cons_cnt = 0;
    logic [31:0] first_pc [3];
    logic [31:0] first_instr [3];
    logic [31:0] last_pc = '0;
    logic [31:0] last_instr = '0;

    always #5 clk_i = ~clk_i;

    instruction_fetch #(
        .RESET_PC      (RESET_PC),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .adr_o        (adr_o),
        .sel_o        (sel_o),
        .we_o         (we_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fault_o      (fault_o),
        .fault_pc_o   (fault_pc_o)
    );

    function automatic logic [31:0] flash_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h1111_1111;
        if (a == 32'h4) return 32'h2222_2222;
        if (a == 32'h8) return 32'h3333_3333;
        if (a == RTY_ADDR) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Flash emulator: one wait state, then responds; addresses >= 0x400 never answer.
    initial begin
        int stb_cnt;
        stb_cnt = 0;
        forever begin
            @(negedge clk_i);
            ack_i = 1'b0;
            err_i = 1'b0;
            rty_i = 1'b0;
            if (cyc_o && stb_o) begin
                stb_cnt++;
                if (stb_cnt >= 2) begin
                    if (adr_o == ERR_ADDR) begin
                        err_i = 1'b1;
                    end else if (rty_arm && adr_o == RTY_ADDR) begin
                        rty_i   = 1'b1;
                        rty_arm = 1'b0;
                    end else if (adr_o < 32'h400) begin
                        ack_i = 1'b1;
                        dat_i = flash_word(adr_o);
                    end
                end
            end else begin
                stb_cnt = 0;
            end
        end
    end

    // Stream model: consumed words must run sequentially from the latest reset/redirect target.
    initial begin
        logic [31:0] exp_pc;
        bit          prev_resp;
        exp_pc    = RESET_PC;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk_i);
            #3;
            if (mon_en) begin
                chk("sel_o", 32'(sel_o), 32'hF);
                chk("we_o", 32'(we_o), 32'h0);
                chk("dat_o", dat_o, 32'h0);
                chk("adr_align", 32'(adr_o[1:0]), 32'h0);
                chk("cyc_eq_stb", 32'(cyc_o), 32'(stb_o));
                if (fault_o) chk("fault_bus_idle", 32'(cyc_o), 32'h0);
                if (prev_resp) chk("stb_gap", 32'(stb_o), 32'h0);
                if (valid_o) begin
                    chk("head_pc", pc_o, exp_pc);
                    chk("head_instr", instr_o, flash_word(exp_pc));
                end
                if (rst_i) begin
                    exp_pc = RESET_PC;
                end else if (redirect_i) begin
                    exp_pc = {redirect_pc_i[31:2], 2'b00};
                end else if (valid_o && ready_i) begin
                    if (cons_cnt < 3) begin
                        first_pc[cons_cnt]    = pc_o;
                        first_instr[cons_cnt] = instr_o;
                    end
                    last_pc    = pc_o;
                    last_instr = instr_o;
                    cons_cnt++;
                    exp_pc += 32'd4;
                end
                prev_resp = stb_o && (ack_i || rty_i || err_i) && !rst_i;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        tick();
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
    endtask

    task automatic wait_cons(input int base, input string name);
        int n;
        n = 0;
        while (cons_cnt <= base && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(cons_cnt > base), 32'h1);
    endtask

    initial begin
        int n;
        int cnt;
        int base;
        repeat (3) tick();
        chk("rst_cyc", 32'(cyc_o), 32'h0);
        chk("rst_stb", 32'(stb_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_fault", 32'(fault_o), 32'h0);
        chk("rst_fault_pc", fault_pc_o, 32'h0);
        chk("rst_adr", adr_o, RESET_PC);
        mon_en  = 1'b1;
        rst_i   = 1'b0;
        ready_i = 1'b1;

        // In-order delivery from reset
        wait_cons(2, "stream_timeout");
        chk("w0_pc", first_pc[0], 32'h0);
        chk("w1_pc", first_pc[1], 32'h4);
        chk("w2_pc", first_pc[2], 32'h8);
        chk("w0_instr", first_instr[0], 32'h1111_1111);
        chk("w1_instr", first_instr[1], 32'h2222_2222);
        chk("w2_instr", first_instr[2], 32'h3333_3333);

        // Decode stalled: the FIFO fills to its depth and the bus goes quiet
        ready_i = 1'b0;
        redirect_to(32'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 12 && stb_o) cnt++;
            tick();
        end
        chk("stall_late_stb", 32'(cnt), 32'h0);
        chk("stall_valid", 32'(valid_o), 32'h1);
        chk("stall_head_pc", pc_o, 32'h0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("stall_second_valid", 32'(valid_o), 32'h1);
        chk("stall_second_pc", pc_o, 32'h4);
        n = 0;
        while (!stb_o && n < 5) begin
            tick();
            n++;
        end
        chk("refill_issue", 32'(stb_o), 32'h1);
        chk("refill_adr", adr_o, 32'h8);
        ready_i = 1'b1;

        // Redirect coinciding with the ack for 0x4
        redirect_to(32'h0);
        n = 0;
        while (!(stb_o && ack_i && adr_o == 32'h4) && n < 40) begin
            tick();
            n++;
        end
        chk("ack4_seen", 32'(stb_o && ack_i && adr_o == 32'h4), 32'h1);
        redirect_to(32'h103);
        chk("redir_valid_low", 32'(valid_o), 32'h0);
        n = 0;
        while (!stb_o && n < 8) begin
            tick();
            n++;
        end
        chk("redir_adr", adr_o, 32'h100);
        base = cons_cnt;
        wait_cons(base, "redir_cons_timeout");
        chk("redir_pc", last_pc, 32'h100);
        chk("redir_instr", last_instr, 32'hC0DE_0100);

        // Watchdog abort on an address the flash never answers
        redirect_to(32'h1000);
        n   = 0;
        cnt = 0;
        while (!fault_o && n < 60) begin
            if (stb_o && adr_o == 32'h1000) cnt++;
            tick();
            n++;
        end
        chk("timeout_fault", 32'(fault_o), 32'h1);
        chk("timeout_len", 32'(cnt), 32'd16);
        chk("timeout_fault_pc", fault_pc_o, 32'h1000);
        chk("timeout_cyc", 32'(cyc_o), 32'h0);
        repeat (3) tick();
        chk("fault_sticky", 32'(fault_o), 32'h1);
        chk("fault_parked", 32'(cyc_o), 32'h0);
        redirect_to(32'h0);
        chk("fault_cleared", 32'(fault_o), 32'h0);
        chk("fault_pc_kept", fault_pc_o, 32'h1000);
        base = cons_cnt;
        wait_cons(base, "resume_timeout");
        chk("resume_pc", last_pc, 32'h0);
        chk("resume_instr", last_instr, 32'h1111_1111);

        // Bus error faults immediately
        redirect_to(ERR_ADDR);
        n = 0;
        while (!fault_o && n < 20) begin
            tick();
            n++;
        end
        chk("err_fault", 32'(fault_o), 32'h1);
        chk("err_fault_pc", fault_pc_o, ERR_ADDR);
        redirect_to(32'h0);
        chk("err_cleared", 32'(fault_o), 32'h0);

        // One retry, then data
        rty_arm = 1'b1;
        redirect_to(RTY_ADDR);
        n = 0;
        while (!(stb_o && rty_i) && n < 30) begin
            tick();
            n++;
        end
        chk("rty_seen", 32'(stb_o && rty_i), 32'h1);
        tick();
        cnt = 0;
        while (!stb_o && cnt < 6) begin
            tick();
            cnt++;
        end
        chk("rty_gap", 32'(cnt), 32'h1);
        chk("rty_reissue_adr", adr_o, RTY_ADDR);
        n = 0;
        while (!(valid_o && pc_o == RTY_ADDR) && n < 10) begin
            tick();
            n++;
        end
        chk("rty_valid", 32'(valid_o && pc_o == RTY_ADDR), 32'h1);
        chk("rty_instr", instr_o, 32'hDEAD_BEEF);

        // Reset in the middle of a read
        n = 0;
        while (!stb_o && n < 10) begin
            tick();
            n++;
        end
        rst_i = 1'b1;
        tick();
        chk("midrst_cyc", 32'(cyc_o), 32'h0);
        chk("midrst_stb", 32'(stb_o), 32'h0);
        chk("midrst_valid", 32'(valid_o), 32'h0);
        chk("midrst_adr", adr_o, RESET_PC);
        tick();
        rst_i = 1'b0;
        base = cons_cnt;
        wait_cons(base, "midrst_cons_timeout");
        chk("midrst_pc", last_pc, 32'h0);
        chk("midrst_instr", last_instr, 32'h1111_1111);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
